// File: rtl/cache_pkg.sv
// Shared types and sizing for the data-cache block fill logic.
// Eight 16-bit words per block, 16-bit byte addresses.
package cache_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int OFF_W       = 3;
  localparam int BLOCK_WORDS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/fill_counter.sv
// Loadable word counter for one side of a block fill (requests or responses).
// Counts 0..2**W and holds there; the offset wraps around the load-time start word.
module fill_counter #(
  parameter int W = cache_pkg::OFF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_start,
  input  logic         i_inc,
  output logic [W:0]   o_count,
  output logic [W-1:0] o_offset,
  output logic         o_done
);

  localparam logic [W:0] FULL = {1'b1, {W{1'b0}}};

  logic [W:0]   r_count;
  logic [W-1:0] r_start;

  // The extra count bit lets a finished fill read as 2**W instead of aliasing to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_start <= '0;
    end else if (i_load) begin
      r_count <= '0;
      r_start <= i_start;
    end else if (i_inc && (r_count != FULL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_done   = (r_count == FULL);
  assign o_offset = r_start + r_count[W-1:0];

endmodule

// File: rtl/cache_fill_fsm.sv
// Data-cache miss handler: streams 8 pipelined word reads and writes the returned words.
// Define CACHE_FILL_CRITICAL_WORD_FIRST_EN to start the fill at the faulting word.
module cache_fill_fsm #(
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int DATA_W = cache_pkg::DATA_W,
  parameter int OFF_W  = cache_pkg::OFF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_detected,
  input  logic [ADDR_W-1:0]    miss_address,
  input  logic                 memory_data_valid,
  input  logic [DATA_W-1:0]    memory_data,
  output logic                 fsm_busy,
  output logic                 mem_read,
  output logic [ADDR_W-1:0]    memory_address,
  output logic                 write_data_array,
  output logic [OFF_W-1:0]     word_offset,
  output logic [2**OFF_W-1:0]  word_en,
  output logic [DATA_W-1:0]    write_data,
  output logic                 write_tag_array
);

  import cache_pkg::*;

  localparam int               WORDS    = 2**OFF_W;
  localparam logic [OFF_W:0]   LAST_IDX = (OFF_W+1)'(WORDS - 1);
  localparam logic [WORDS-1:0] ONE_HOT0 = {{(WORDS-1){1'b0}}, 1'b1};

  fill_state_t                r_state;
  logic [ADDR_W-1:OFF_W+1]    r_blk_addr;

  logic                       w_fill;
  logic                       w_load;
  logic                       w_write;
  logic                       w_last;
  logic [OFF_W-1:0]           w_start;
  logic [OFF_W:0]             w_req_count;
  logic [OFF_W:0]             w_rsp_count;
  logic [OFF_W-1:0]           w_req_off;
  logic [OFF_W-1:0]           w_rsp_off;
  logic                       w_req_done;
  logic                       w_rsp_done;
  logic                       w_unused_bits;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign w_start = miss_address[OFF_W:1];
`else
  assign w_start = '0;
`endif

  assign w_unused_bits = ^{miss_address[OFF_W:0], w_req_count};

  assign w_fill  = (r_state == FILL);
  assign w_load  = !w_fill && miss_detected;
  assign w_write = w_fill && memory_data_valid && !w_rsp_done;
  assign w_last  = w_write && (w_rsp_count == LAST_IDX);

  fill_counter #(.W(OFF_W)) u_req_counter (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_start  (w_start),
    .i_inc    (w_fill),
    .o_count  (w_req_count),
    .o_offset (w_req_off),
    .o_done   (w_req_done)
  );

  fill_counter #(.W(OFF_W)) u_rsp_counter (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_start  (w_start),
    .i_inc    (w_write),
    .o_count  (w_rsp_count),
    .o_offset (w_rsp_off),
    .o_done   (w_rsp_done)
  );

  // Misses are only taken in IDLE, so the final-write cycle can never start a new fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_blk_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (miss_detected) begin
            r_blk_addr <= miss_address[ADDR_W-1:OFF_W+1];
            r_state    <= FILL;
          end
        end
        FILL: begin
          if (w_last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fsm_busy         = w_fill;
  assign mem_read         = w_fill && !w_req_done;
  assign memory_address   = w_fill ? {r_blk_addr, w_req_off, 1'b0} : '0;
  assign write_data_array = w_write;
  assign word_offset      = w_write ? w_rsp_off : '0;
  assign word_en          = w_write ? (ONE_HOT0 << w_rsp_off) : '0;
  assign write_data       = memory_data;
  assign write_tag_array  = w_last;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a pipelined 4-cycle memory responder.
// Honours CACHE_FILL_CRITICAL_WORD_FIRST_EN when building the expected word order.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_offset;
  logic [7:0]  word_en;
  logic [15:0] write_data;
  logic        write_tag_array;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read          (mem_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_offset       (word_offset),
    .word_en           (word_en),
    .write_data        (write_data),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } pend_t;

  typedef struct {
    logic [2:0]  off;
    logic [15:0] data;
    bit          last;
  } wr_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  pend_t       rq[$];
  logic [15:0] expReq[$];
  wr_t         expWr[$];
  bit          expBusy = 1'b0;
  int          wordsDelivered = 0;
  int          gapAfter = -1;
  int          gapLen = 0;
  int          gapLeft = 0;
  bit          spurious = 1'b0;
  bit          randGaps = 1'b0;
  logic [15:0] seed;

  // Memory contents are a fixed scramble of the word address.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A ^ seed;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Expected fill: 8 word addresses and 8 writes, wrapping from the start word.
  task automatic pushFill(input logic [15:0] a);
    int          start;
    logic [15:0] ad;
    wr_t         w;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    start = int'(a[3:1]);
`else
    start = 0;
`endif
    for (int i = 0; i < 8; i++) begin
      int off;
      off = (start + i) % 8;
      ad = (a & 16'hFFF0) | 16'(off * 2);
      expReq.push_back(ad);
      w.off  = 3'(off);
      w.data = memWord(ad);
      w.last = (i == 7);
      expWr.push_back(w);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: each request seen in cycle c returns its word in cycle c+4 or later.
  initial begin
    pend_t p;
    memory_data_valid = 1'b0;
    memory_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (gapLeft > 0) begin
        gapLeft--;
        memory_data_valid = 1'b0;
        memory_data = 16'($urandom);
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        p = rq.pop_front();
        memory_data_valid = 1'b1;
        memory_data = memWord(p.addr);
        wordsDelivered++;
        if (wordsDelivered == gapAfter) gapLeft = gapLen;
        else if (randGaps && $urandom_range(0, 5) == 0) gapLeft = $urandom_range(1, 3);
      end else if (spurious && !expBusy && $urandom_range(0, 2) == 0) begin
        memory_data_valid = 1'b1;
        memory_data = 16'($urandom);
      end else begin
        memory_data_valid = 1'b0;
        memory_data = 16'($urandom);
      end
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin
    bit          nextBusy;
    bit          monWrite;
    logic [15:0] monA;
    wr_t         monW;
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("rst_busy", 32'(fsm_busy), 32'(0));
        checkOutput("rst_mem_read", 32'(mem_read), 32'(0));
        checkOutput("rst_write", 32'(write_data_array), 32'(0));
        checkOutput("rst_tag", 32'(write_tag_array), 32'(0));
        checkOutput("rst_word_en", 32'(word_en), 32'(0));
        expReq.delete();
        expWr.delete();
        expBusy = 1'b0;
      end else begin
        nextBusy = expBusy;
        checkOutput("busy", 32'(fsm_busy), 32'(expBusy));
        checkOutput("mem_read", 32'(mem_read), 32'(expBusy && (expReq.size() > 0)));
        if (mem_read) begin
          if (expReq.size() > 0) begin
            monA = expReq.pop_front();
            checkOutput("req_addr", 32'(memory_address), 32'(monA));
          end
          rq.push_back('{cyc + 4, memory_address});
        end else if (!expBusy) begin
          checkOutput("idle_addr", 32'(memory_address), 32'(0));
        end
        checkOutput("wdata_pass", 32'(write_data), 32'(memory_data));
        monWrite = expBusy && memory_data_valid && (expWr.size() > 0);
        checkOutput("wr_en", 32'(write_data_array), 32'(monWrite));
        if (monWrite) begin
          monW = expWr.pop_front();
          checkOutput("word_offset", 32'(word_offset), 32'(monW.off));
          checkOutput("word_en", 32'(word_en), 32'(8'h01 << monW.off));
          checkOutput("write_data", 32'(write_data), 32'(monW.data));
          checkOutput("tag_pulse", 32'(write_tag_array), 32'(monW.last));
          if (monW.last) nextBusy = 1'b0;
        end else begin
          checkOutput("idle_word_en", 32'(word_en), 32'(0));
          checkOutput("idle_tag", 32'(write_tag_array), 32'(0));
        end
        if (!expBusy && miss_detected) begin
          pushFill(miss_address);
          nextBusy = 1'b1;
        end
        expBusy = nextBusy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!expBusy) return;
      tick();
    end
    timeoutFail(name);
  endtask

  // Issue one miss from IDLE, optionally keep poking misses during the fill, then wait it out.
  task automatic applyStimulus(input logic [15:0] a, input int ignoredMisses);
    waitIdle("pre_idle", 300);
    miss_detected = 1'b1;
    miss_address  = a;
    tick();
    miss_detected = 1'b0;
    for (int k = 0; k < ignoredMisses; k++) begin
      miss_detected = 1'b1;
      miss_address  = 16'($urandom);
      tick();
    end
    miss_detected = 1'b0;
    waitIdle("fill_done", 300);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = '0;
    seed = 16'($urandom);
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] basic fill");
    applyStimulus(16'h1234, 0);

    $display("[TB] gapped returns");
    gapAfter = wordsDelivered + 3;
    gapLen = 3;
    applyStimulus(16'h5678, 0);
    gapAfter = -1;

    $display("[TB] ignored events");
    spurious = 1'b1;
    repeat (4) tick();
    applyStimulus(16'h1234, 6);
    repeat (4) tick();

    $display("[TB] back-to-back misses");
    waitIdle("b2b_pre", 300);
    miss_detected = 1'b1;
    miss_address = 16'h2468;
    tick();
    waitIdle("b2b_first", 300);
    tick();
    miss_detected = 1'b0;
    waitIdle("b2b_second", 300);

    $display("[TB] critical word miss");
    applyStimulus(16'h00AC, 0);

    $display("[TB] reset mid-fill");
    waitIdle("rst_pre", 300);
    base = wordsDelivered;
    miss_detected = 1'b1;
    miss_address = 16'h4444;
    tick();
    miss_detected = 1'b0;
    for (int i = 0; i < 100 && wordsDelivered < base + 4; i++) @(negedge clk);
    if (wordsDelivered < base + 4) timeoutFail("rst_wait_words");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", 32'(fsm_busy), 32'(0));
    checkOutput("async_rst_write", 32'(write_data_array), 32'(0));
    checkOutput("async_rst_word_en", 32'(word_en), 32'(0));
    checkOutput("async_rst_tag", 32'(write_tag_array), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 50 && rq.size() > 0; i++) tick();
    if (rq.size() > 0) timeoutFail("rst_stale_drain");
    repeat (3) tick();

    $display("[TB] randomized fills");
    randGaps = 1'b1;
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus(16'($urandom), $urandom_range(0, 6));
    end

    waitIdle("final_idle", 300);
    for (int i = 0; i < 50 && rq.size() > 0; i++) tick();
    repeat (3) tick();
    checkOutput("leftover_req", 32'(expReq.size()), 32'(0));
    checkOutput("leftover_wr", 32'(expWr.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler for the data cache's 8-word block.
- On a miss it issues 8 pipelined word reads to main memory and accepts the returned words in order.
- For each returned word it drives the binary word offset and the matching one-hot word enable into the data array, then pulses the tag write.
- It generates offsets and write enables, so it sits between the cache controller, the memory model and the data/tag arrays.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 16, memory word width.
- OFF_W, 3, word-offset width; block holds 2**OFF_W words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- miss_detected  in  1  cache miss this cycle; sampled only in IDLE.
- miss_address  in  ADDR_W  faulting byte address; sampled with miss_detected.
- memory_data_valid  in  1  memory_data carries the next returned word.
- memory_data  in  DATA_W  returned word; passed through unregistered.
- fsm_busy  out  1  fill in progress; the controller stalls the pipeline.
- mem_read  out  1  read request valid for memory_address this cycle.
- memory_address  out  ADDR_W  word request address.
- write_data_array  out  1  write the current word into the data array.
- word_offset  out  OFF_W  binary offset of the word being written.
- word_en  out  2**OFF_W  one-hot of word_offset; all zero when not writing.
- write_data  out  DATA_W  equals memory_data.
- write_tag_array  out  1  single-cycle pulse with the final data write.

Behaviour:
- States are IDLE and FILL, held in a 1-bit state register with asynchronous reset to IDLE.
- Registers are blk_addr[ADDR_W-1:OFF_W+1], req_cnt[OFF_W:0] and rsp_cnt[OFF_W:0].
- Reset, including mid-fill:
  - state=IDLE; counters=0.
  - fsm_busy, mem_read, write_data_array and write_tag_array are 0; word_en is 0.
  - The partial fill is abandoned and no tag write occurs.
  - Late memory_data_valid arriving after reset is ignored.
- IDLE:
  - All outputs are 0 except write_data.
  - miss_detected=1: latch miss_address[ADDR_W-1:OFF_W+1], clear both counters, move to FILL next cycle.
- FILL:
  - fsm_busy=1.
  - mem_read=1 while req_cnt<8.
  - memory_address = {blk_addr, req_cnt[OFF_W-1:0], 1'b0}.
  - req_cnt increments every cycle until it reaches 8, then holds.
- Memory is pipelined: one request per cycle, and the memory model returns data 4 cycles later in order.
  - The FSM does not count latency; it relies solely on memory_data_valid.
- memory_data_valid=1 in FILL:
  - write_data_array=1 combinationally in the same cycle.
  - word_offset = rsp_cnt[OFF_W-1:0]; word_en = 1<<word_offset.
  - rsp_cnt increments.
- Final word (rsp_cnt==7 with valid):
  - write_tag_array=1 in the same cycle.
  - The next state is IDLE; fsm_busy drops on the following cycle.
- Fill latency:
  - 12 cycles from the FILL entry edge to the final write with the nominal 4-cycle memory.
  - Gaps in memory_data_valid stretch the fill; no timeout.
- memory_data_valid in IDLE is ignored.
- miss_detected during FILL is ignored; the controller re-asserts it after fsm_busy falls.
- Miss in the same cycle as the final write is not accepted; it is taken at the earliest one cycle later, in IDLE.
- Counter wrap: counters are OFF_W+1 bits, so 8 is representable and does not alias to 0.

Optional Feature:
- Macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - On miss, latch start = miss_address[OFF_W:1].
  - Request and write offsets are (start + count) mod 8, wrapping 7->0.
  - The tag write still accompanies the 8th returned word.
- Undefined:
  - Offsets run 0..7 regardless of miss_address[OFF_W:1].

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_W, DATA_W, OFF_W, BLOCK_WORDS=8.
  - The fill_state_t enum {IDLE, FILL}.
- One sub-module, fill_counter:
  - Loadable OFF_W+1-bit counter with start value, increment enable and done flag (count==8).
  - Instantiated twice, for requests and responses.
  - The wrap offset, start+count[OFF_W-1:0], is computed inside it.

Test Plan:
- Basic fill:
  - Stimulus: miss at 0x1234, then valid on 8 consecutive cycles starting 4 cycles after the FILL entry edge.
  - Response: requests 0x1230,0x1232,…,0x123E; word_en 0x01..0x80 in order; write_tag_array only with word_en=0x80; fsm_busy low one cycle later.
- Gapped returns:
  - Stimulus: valid deasserted for 3 cycles after word 2.
  - Response: no writes during the gap; offsets resume at 3; tag pulse with offset 7.
- Reset mid-fill:
  - Stimulus: assert rst after 4 words, then supply 4 more valids.
  - Response: all outputs 0 immediately; no writes; no tag pulse; state IDLE.
- Ignored events:
  - Stimulus: valid in IDLE, and miss during FILL.
  - Response: no write_data_array; block address unchanged (0x1230 requests continue).
- Back-to-back misses:
  - Stimulus: miss held high through the final write.
  - Response: new fill starts the cycle after fsm_busy drops, never on the final-write cycle.
- With CACHE_FILL_CRITICAL_WORD_FIRST_EN defined:
  - Stimulus: miss at 0x00AC.
  - Response: requests 0x00AC,0x00AE,0x00A0..0x00AA; word_offset sequence 6,7,0,1,2,3,4,5; tag pulse with offset 5.
